// File: rtl/inst_decoder_pkg.sv
`default_nettype none
// =============================================================================
// Module : inst_decoder_pkg
// Opcodes, instruction field layout and FSM state encoding for inst_decoder.
// Rev    : 1.0
// =============================================================================
package inst_decoder_pkg;

   localparam int OPC_BITS = 4;

   localparam logic [3:0] OP_NOP     = 4'h0;
   localparam logic [3:0] OP_LOAD_W  = 4'h1;
   localparam logic [3:0] OP_LOAD_A  = 4'h2;
   localparam logic [3:0] OP_COMPUTE = 4'h3;
   localparam logic [3:0] OP_STORE   = 4'h4;
   localparam logic [3:0] OP_HALT    = 4'hF;

   // LSB positions of each field in the 128-bit instruction word
   localparam int OPC_LSB = 124;
   localparam int SRC_LSB = 92;
   localparam int DST_LSB = 60;
   localparam int LEN_LSB = 44;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_HALTED = 3'd5
   } state_e;

   function automatic logic [3:0] norm_op(input logic [3:0] raw);
      case (raw)
         OP_LOAD_W, OP_LOAD_A, OP_COMPUTE, OP_STORE, OP_HALT: return raw;
         default:                                             return OP_NOP;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/inst_decoder_addr_gen.sv
`default_nettype none
// =============================================================================
// Module : inst_addr_gen
// Loadable src/dst address counters and beat down-counter; done flags last beat.
// Rev    : 1.0
// =============================================================================
module inst_addr_gen #(
   parameter int ADDR_BITS = 32,
   parameter int LEN_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic [ADDR_BITS-1:0] src_i,
   input  logic [ADDR_BITS-1:0] dst_i,
   input  logic [LEN_BITS-1:0]  len_i,
   output logic [ADDR_BITS-1:0] src_o,
   output logic [ADDR_BITS-1:0] dst_o,
   output logic                 done_o
);

   logic [ADDR_BITS-1:0] src_q, src_d;
   logic [ADDR_BITS-1:0] dst_q, dst_d;
   logic [LEN_BITS-1:0]  cnt_q, cnt_d;

   always_comb begin
      src_d = src_q;
      dst_d = dst_q;
      cnt_d = cnt_q;
      if (load_i) begin
         src_d = src_i;
         dst_d = dst_i;
         cnt_d = len_i;
      end else if (step_i) begin
         src_d = src_q + ADDR_BITS'(1);
         dst_d = dst_q + ADDR_BITS'(1);
         cnt_d = cnt_q - LEN_BITS'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q <= '0;
         dst_q <= '0;
         cnt_q <= '0;
      end else begin
         src_q <= src_d;
         dst_q <= dst_d;
         cnt_q <= cnt_d;
      end
   end

   assign src_o  = src_q;
   assign dst_o  = dst_q;
   assign done_o = (cnt_q == LEN_BITS'(1));

endmodule
`default_nettype wire

// File: rtl/inst_decoder.sv
`default_nettype none
// =============================================================================
// Module : inst_decoder
// Fetches, decodes and expands instructions into per-beat memory/array strobes.
// Rev    : 1.0
// =============================================================================
module inst_decoder
   import inst_decoder_pkg::*;
#(
   parameter int INST_BITS    = 128,
   parameter int ADDR_BITS    = 32,
   parameter int LEN_BITS     = 16,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [INST_BITS-1:0] instruction,
   input  logic                 inst_valid,
   input  logic                 ib_complete,
   output logic                 flag,
   input  logic                 ready,
   output logic [3:0]           op,
   output logic                 beat_valid,
   output logic                 rd_en,
   output logic [ADDR_BITS-1:0] rd_addr,
   output logic                 wr_en,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic                 sa_en,
   output logic                 busy,
   output logic                 halted
);

   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   state_e               state_q;
   logic                 flag_q;
   logic [3:0]           op_q;
   logic                 beat_valid_q;
   logic                 rd_en_q;
   logic                 wr_en_q;
   logic                 sa_en_q;
   logic [DRAIN_W-1:0]   drain_q;

   logic [3:0]           w_op;
   logic [ADDR_BITS-1:0] w_src;
   logic [ADDR_BITS-1:0] w_dst;
   logic [LEN_BITS-1:0]  w_len;
   logic                 w_load;
   logic                 w_step;
   logic                 w_last;
   logic                 unused_reserved;

   assign w_op   = norm_op(instruction[OPC_LSB +: OPC_BITS]);
   assign w_src  = instruction[SRC_LSB +: ADDR_BITS];
   assign w_dst  = instruction[DST_LSB +: ADDR_BITS];
   assign w_len  = instruction[LEN_LSB +: LEN_BITS];
   assign unused_reserved = ^instruction[LEN_LSB-1:0];

   assign w_load = (state_q == ST_WAIT) && inst_valid && !ib_complete;
   assign w_step = (state_q == ST_EXEC) && beat_valid_q && ready;

   inst_addr_gen #(
      .ADDR_BITS (ADDR_BITS),
      .LEN_BITS  (LEN_BITS)
   ) u_addr_gen (
      .clk    (clk),
      .reset  (reset),
      .load_i (w_load),
      .step_i (w_step),
      .src_i  (w_src),
      .dst_i  (w_dst),
      .len_i  (w_len),
      .src_o  (rd_addr),
      .dst_o  (wr_addr),
      .done_o (w_last)
   );

   // Every retirement path returns to FETCH only while start is still held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         flag_q       <= 1'b0;
         op_q         <= OP_NOP;
         beat_valid_q <= 1'b0;
         rd_en_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         sa_en_q      <= 1'b0;
         drain_q      <= '0;
      end else begin
         flag_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_FETCH;
                  flag_q  <= 1'b1;
               end
            end
            ST_FETCH: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (inst_valid) begin
                  if (ib_complete) begin
                     state_q <= ST_HALTED;
                  end else begin
                     op_q <= w_op;
                     if (w_op == OP_HALT) begin
                        state_q <= ST_HALTED;
                     end else if (w_op == OP_NOP || w_len == '0) begin
                        state_q <= start ? ST_FETCH : ST_IDLE;
                        flag_q  <= start;
                     end else begin
                        state_q      <= ST_EXEC;
                        beat_valid_q <= 1'b1;
                        rd_en_q      <= (w_op == OP_LOAD_W) || (w_op == OP_LOAD_A);
                        wr_en_q      <= (w_op == OP_STORE);
                        sa_en_q      <= (w_op == OP_COMPUTE);
                     end
                  end
               end
            end
            ST_EXEC: begin
               if (w_step && w_last) begin
                  beat_valid_q <= 1'b0;
                  rd_en_q      <= 1'b0;
                  wr_en_q      <= 1'b0;
                  sa_en_q      <= 1'b0;
                  if (op_q == OP_COMPUTE) begin
                     state_q <= ST_DRAIN;
                     drain_q <= DRAIN_W'(DRAIN_CYCLES - 1);
                  end else begin
                     state_q <= start ? ST_FETCH : ST_IDLE;
                     flag_q  <= start;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_q == '0) begin
                  state_q <= start ? ST_FETCH : ST_IDLE;
                  flag_q  <= start;
               end else begin
                  drain_q <= drain_q - DRAIN_W'(1);
               end
            end
            ST_HALTED: begin
               if (!start) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign flag       = flag_q;
   assign op         = op_q;
   assign beat_valid = beat_valid_q;
   assign rd_en      = rd_en_q;
   assign wr_en      = wr_en_q;
   assign sa_en      = sa_en_q;
   assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALTED);
   assign halted     = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_inst_decoder.sv
`default_nettype none
// =============================================================================
// Module : tb_inst_decoder
// Scoreboard bench: instruction-buffer model, beat reference model, monitor.
// Rev    : 1.0
// =============================================================================
module tb_inst_decoder;

   localparam int AB = 32;
   localparam int LB = 16;
   localparam int DC = 8;

   logic          clk = 1'b0;
   logic          reset, start, inst_valid, ib_complete, ready;
   logic [127:0]  instruction;
   logic          flag, beat_valid, rd_en, wr_en, sa_en, busy, halted;
   logic [3:0]    op;
   logic [AB-1:0] rd_addr, wr_addr;

   inst_decoder #(
      .INST_BITS    (128),
      .ADDR_BITS    (AB),
      .LEN_BITS     (LB),
      .DRAIN_CYCLES (DC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .instruction (instruction),
      .inst_valid  (inst_valid),
      .ib_complete (ib_complete),
      .flag        (flag),
      .ready       (ready),
      .op          (op),
      .beat_valid  (beat_valid),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .sa_en       (sa_en),
      .busy        (busy),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   typedef struct { logic [3:0] op; logic [31:0] src; logic [31:0] dst; } beat_t;
   typedef struct { logic [127:0] inst; bit ibc; } prog_t;

   beat_t sb[$];
   prog_t prog[$];
   int    beat_cyc[$];
   int    flag_cyc[$];
   bit    rdy_pat[$];
   int    flag_rises = 0;
   int    cyc = 0;
   int    iv_cyc = 0;
   int    checks = 0;
   int    errors = 0;
   bit    rdy_rand = 0;
   logic [3:0] ops_tbl [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hC};

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: an instruction expands into len beats at src+i / dst+i.
   task automatic push_inst(input logic [3:0] opc, input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input bit ibc);
      prog_t p;
      beat_t b;
      logic [43:0] rsv;
      rsv    = 44'({$urandom(), $urandom()});
      p.inst = {opc, src, dst, len, rsv};
      p.ibc  = ibc;
      prog.push_back(p);
      if (!ibc && (opc == 4'h1 || opc == 4'h2 || opc == 4'h3 || opc == 4'h4)) begin
         for (int i = 0; i < int'(len); i++) begin
            b.op  = opc;
            b.src = src + 32'(i);
            b.dst = dst + 32'(i);
            sb.push_back(b);
         end
      end
   endtask

   task automatic clear_logs();
      beat_cyc.delete();
      flag_cyc.delete();
      flag_rises = 0;
   endtask

   task automatic go();
      @(posedge clk); #1;
      start = 1'b1;
   endtask

   task automatic run_until_halted(input int maxc, input string nm);
      int n = 0;
      while (!halted && n < maxc) begin
         @(negedge clk); #1;
         n++;
      end
      check(nm, halted, 1);
   endtask

   task automatic stop_and_idle(input string nm);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check(nm, {busy, halted, flag}, 0);
   endtask

   // Instruction buffer: one instruction, one cycle after each flag rise
   initial begin
      bit fl_prev, rise;
      prog_t p;
      fl_prev = 0;
      inst_valid = 0; ib_complete = 0; instruction = '0;
      forever begin
         @(negedge clk);
         rise    = flag && !fl_prev;
         fl_prev = flag;
         @(posedge clk); #1;
         inst_valid  = 0;
         ib_complete = 0;
         if (rise && !reset && prog.size() > 0) begin
            p           = prog.pop_front();
            instruction = p.inst;
            ib_complete = p.ibc;
            inst_valid  = 1;
         end
      end
   end

   // Downstream ready: scripted pattern during beats, else random or always-on
   initial begin
      ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (beat_valid && rdy_pat.size() > 0) ready = rdy_pat.pop_front();
         else if (rdy_rand)                     ready = ($urandom_range(0, 2) != 0);
         else                                   ready = 1'b1;
      end
   end

   // Monitor: pops the scoreboard on each accepted beat
   initial begin
      bit fl_prev, hold, bad;
      logic [71:0] snap, now;
      beat_t e;
      fl_prev = 0; hold = 0; snap = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            hold = 0; fl_prev = 0;
            continue;
         end
         if (inst_valid) iv_cyc = cyc;
         if (flag) begin
            checks++;
            if (fl_prev) begin
               errors++;
               $display("FAIL flag_width: flag high again at cycle %0d, required one-cycle pulse", cyc);
            end else begin
               flag_rises++;
               flag_cyc.push_back(cyc);
            end
         end
         fl_prev = flag;
         if (!beat_valid && (rd_en || wr_en || sa_en)) begin
            checks++; errors++;
            $display("FAIL stray_strobe: rd=%0b wr=%0b sa=%0b with beat_valid=0, required all 0", rd_en, wr_en, sa_en);
         end
         now = {beat_valid, rd_en, wr_en, sa_en, op, rd_addr, wr_addr};
         if (hold) begin
            checks++;
            if (now !== snap) begin
               errors++;
               $display("FAIL hold_on_stall: outputs 0x%0h, required unchanged 0x%0h", now, snap);
            end
         end
         hold = beat_valid && !ready;
         snap = now;
         if (beat_valid && ready) begin
            beat_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected: op=%0h rd_addr=%0h wr_addr=%0h, required no beat", op, rd_addr, wr_addr);
            end else begin
               e   = sb.pop_front();
               bad = (op !== e.op) || (rd_en !== (e.op == 4'h1 || e.op == 4'h2)) ||
                     (wr_en !== (e.op == 4'h4)) || (sa_en !== (e.op == 4'h3)) ||
                     ((e.op == 4'h1 || e.op == 4'h2) && rd_addr !== e.src) ||
                     ((e.op == 4'h4) && wr_addr !== e.dst);
               if (bad) begin
                  errors++;
                  $display("FAIL beat: got op=%0h rd=%0b wr=%0b sa=%0b rd_addr=%0h wr_addr=%0h, required op=%0h src=%0h dst=%0h",
                           op, rd_en, wr_en, sa_en, rd_addr, wr_addr, e.op, e.src, e.dst);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int n, exp_beats, d0, d1;
      reset = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {flag, beat_valid, rd_en, wr_en, sa_en, busy, halted, op, rd_addr, wr_addr}, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("idle_no_flag", {flag_rises[7:0], busy}, 0);

      // LOAD_W src=0x100 len=4 at full throughput
      clear_logs();
      push_inst(4'h1, 32'h100, 32'h0, 16'd4, 0);
      push_inst(4'hF, 32'h0, 32'h0, 16'd0, 0);
      go();
      run_until_halted(200, "A_halted");
      check("A_beats", beat_cyc.size(), 4);
      check("A_consecutive", (beat_cyc.size() == 4) ? beat_cyc[3] - beat_cyc[0] : -1, 3);
      check("A_flags", flag_rises, 2);
      check("A_flag_after_last", (flag_cyc.size() == 2 && beat_cyc.size() == 4) ? flag_cyc[1] - beat_cyc[3] : -1, 1);
      check("A_busy_in_halt", busy, 0);
      stop_and_idle("A_idle");

      // STORE across address wrap with ready stalling
      clear_logs();
      rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
      push_inst(4'h4, 32'h0, 32'hFFFF_FFFE, 16'd3, 0);
      push_inst(4'hF, 32'h0, 32'h0, 16'd0, 0);
      go();
      run_until_halted(200, "B_halted");
      check("B_beats", beat_cyc.size(), 3);
      check("B_sb_empty", sb.size(), 0);
      stop_and_idle("B_idle");

      // COMPUTE len=2: drain before next fetch
      clear_logs();
      push_inst(4'h3, 32'h40, 32'h80, 16'd2, 0);
      push_inst(4'hF, 32'h0, 32'h0, 16'd0, 0);
      go();
      run_until_halted(200, "C_halted");
      check("C_beats", beat_cyc.size(), 2);
      check("C_drain_gap", (flag_cyc.size() == 2 && beat_cyc.size() == 2) ? flag_cyc[1] - beat_cyc[1] : -1, DC + 1);
      stop_and_idle("C_idle");

      // NOP, zero-length LOAD_A, HALT
      clear_logs();
      push_inst(4'h0, 32'h1, 32'h2, 16'd7, 0);
      push_inst(4'h2, 32'h3, 32'h4, 16'd0, 0);
      push_inst(4'hF, 32'h0, 32'h0, 16'd0, 0);
      go();
      run_until_halted(200, "D_halted");
      check("D_flags", flag_rises, 3);
      check("D_no_beats", beat_cyc.size(), 0);
      d0 = (flag_cyc.size() == 3) ? flag_cyc[1] - flag_cyc[0] : 0;
      d1 = (flag_cyc.size() == 3) ? flag_cyc[2] - flag_cyc[1] : 0;
      check("D_flag_spacing", (d0 >= 2) && (d1 >= 2), 1);
      stop_and_idle("D_idle");

      // ib_complete discards the delivered LOAD_W
      clear_logs();
      push_inst(4'h1, 32'h500, 32'h0, 16'd5, 1);
      go();
      run_until_halted(200, "E_halted");
      check("E_halt_latency", cyc - iv_cyc, 1);
      check("E_no_beats", beat_cyc.size(), 0);
      stop_and_idle("E_idle");

      // start dropped mid-instruction: finish the beats, then IDLE
      clear_logs();
      push_inst(4'h2, 32'h900, 32'h0, 16'd5, 0);
      go();
      n = 0;
      while (beat_cyc.size() < 1 && n < 100) begin @(negedge clk); #1; n++; end
      start = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("G_beats", beat_cyc.size(), 5);
      check("G_flags", flag_rises, 1);
      check("G_idle", {busy, halted}, 0);

      // Randomized program under random back-pressure
      clear_logs();
      rdy_rand = 1;
      for (int i = 0; i < 12; i++) begin
         logic [31:0] s;
         s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : 32'($urandom());
         push_inst(ops_tbl[$urandom_range(0, 6)], s, 32'($urandom()), 16'($urandom_range(0, 6)), 0);
      end
      push_inst(4'hF, 32'h0, 32'h0, 16'd0, 0);
      exp_beats = sb.size();
      go();
      run_until_halted(3000, "R_halted");
      check("R_sb_empty", sb.size(), 0);
      check("R_beats", beat_cyc.size(), exp_beats);
      check("R_flags", flag_rises, 13);
      rdy_rand = 0;
      stop_and_idle("R_idle");

      // Asynchronous reset during LOAD_W beat 4
      clear_logs();
      push_inst(4'h1, 32'h200, 32'h0, 16'd10, 0);
      go();
      n = 0;
      while (beat_cyc.size() < 4 && n < 100) begin @(negedge clk); #1; n++; end
      check("F_reach_beat4", beat_cyc.size(), 4);
      reset = 1'b1;
      #1;
      check("F_async_reset", {flag, beat_valid, rd_en, wr_en, sa_en, busy, halted, rd_addr}, 0);
      sb.delete();
      prog.delete();
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      clear_logs();
      repeat (5) @(negedge clk);
      #1;
      check("F_no_flag_without_start", {flag_rises[7:0], busy}, 0);
      push_inst(4'hF, 32'h0, 32'h0, 16'd0, 0);
      go();
      run_until_halted(100, "F_restart_halted");
      check("F_restart_flags", flag_rises, 1);
      stop_and_idle("F_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
